// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory controller: load/store funct3 codes,
// FSM state encoding and the captured request bundle.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RDW     = 3'd2,
    S_WR      = 3'd3,
    S_RMW_RD  = 3'd4,
    S_RMW_MRG = 3'd5,
    S_RMW_WR  = 3'd6,
    S_RESP    = 3'd7
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/lane_fmt.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word
// insertion into an existing word for read-modify-write stores.
module lane_fmt
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_val
);

  logic [31:0] shifted_s;

  // Load formatting: move the addressed lane to bit 0, then extend
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    load_val  = 32'h0000_0000;
    case (funct3)
      F3_B:    load_val = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_val = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_val = shifted_s;
      F3_BU:   load_val = {24'h00_0000, shifted_s[7:0]};
      F3_HU:   load_val = {16'h0000, shifted_s[15:0]};
      default: load_val = 32'h0000_0000;
    endcase
  end

  // Store merge: overwrite only the addressed lane(s) of the old word
  always_comb begin
    store_val = rdata;
    case (funct3)
      F3_B:    store_val[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    store_val[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_val = wdata;
      default: store_val = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store responder for the multicycle core: one request at a time, drives a
// single-port word RAM with 1-cycle read latency, RMW for sub-word stores.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state_r, state_nx;
  mem_req_t    req_r;        // wdata field doubles as the write buffer
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;
  logic        legal_s, misal_s, err_s, accept_s;
  logic [31:0] load_val_s, store_val_s;
  logic        unused_addr_s;

  assign accept_s = (state_r == S_IDLE) && req_valid;

  // Classify the incoming request: legal funct3 for its direction and alignment
  always_comb begin
    legal_s = 1'b0;
    misal_s = 1'b0;
    case (req_funct3)
      F3_B:  legal_s = 1'b1;
      F3_H: begin
        legal_s = 1'b1;
        misal_s = req_addr[0];
      end
      F3_W: begin
        legal_s = 1'b1;
        misal_s = (req_addr[1:0] != 2'b00);
      end
      F3_BU: legal_s = ~req_we;
      F3_HU: begin
        legal_s = ~req_we;
        misal_s = req_addr[0];
      end
      default: begin
        legal_s = 1'b0;
        misal_s = 1'b0;
      end
    endcase
    err_s = ~legal_s | misal_s;
  end

  lane_fmt u_lane_fmt (
    .rdata     (mem_rdata),
    .lane      (req_r.addr[1:0]),
    .funct3    (req_r.funct3),
    .wdata     (req_r.wdata),
    .load_val  (load_val_s),
    .store_val (store_val_s)
  );

  // Next-state decode
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (!req_valid)          state_nx = S_IDLE;
        else if (err_s)          state_nx = S_RESP;
        else if (!req_we)        state_nx = S_RD;
        else if (req_funct3 == F3_W) state_nx = S_WR;
        else                     state_nx = S_RMW_RD;
      end
      S_RD:      state_nx = S_RDW;
      S_RDW:     state_nx = S_RESP;
      S_WR:      state_nx = S_RESP;
      S_RMW_RD:  state_nx = S_RMW_MRG;
      S_RMW_MRG: state_nx = S_RMW_WR;
      S_RMW_WR:  state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx;
  end

  // Request capture at accept; merged word replaces store data during RMW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r <= '{we: 1'b0, funct3: 3'b000, addr: 32'h0000_0000, wdata: 32'h0000_0000};
    end else if (accept_s) begin
      req_r <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
    end else if (state_r == S_RMW_MRG) begin
      req_r.wdata <= store_val_s;
    end
  end

  // Response data/error, loaded on the cycle before RESP and held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (state_r == S_RDW) begin
      rsp_rdata_r <= load_val_s;
      rsp_err_r   <= 1'b0;
    end else if ((state_r == S_WR) || (state_r == S_RMW_WR)) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s && err_s) begin
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b1;
    end
  end

  assign req_ready = (state_r == S_IDLE);
  assign rsp_valid = (state_r == S_RESP);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_en    = (state_r == S_RD) || (state_r == S_WR) ||
                     (state_r == S_RMW_RD) || (state_r == S_RMW_WR);
  assign mem_we    = (state_r == S_WR) || (state_r == S_RMW_WR);
  assign mem_addr  = req_r.addr[MEM_AW+1:2];
  assign mem_wdata = req_r.wdata;

  // Upper address bits are deliberately dropped so accesses wrap modulo RAM size
  assign unused_addr_s = ^req_r.addr[31:MEM_AW+2];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a behavioural word RAM.
module tb_data_mem_ctrl;
  import mem_pkg::*;

  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  logic              pre_we = 1'b0;
  logic [MEM_AW-1:0] pre_addr = '0;
  logic [31:0]       pre_data = 32'h0;
  logic [31:0]       ram [0:(1<<MEM_AW)-1];

  int total = 0, bad = 0;
  int en_cnt = 0, we_cnt = 0, rsp_cnt = 0, acc_cnt = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous RAM model with a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  // Activity counters
  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_we) we_cnt <= we_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (rst_n && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    pre_addr = byte_addr[MEM_AW+1:2];
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input int lat,
                      input logic [31:0] erd, input logic eerr);
    int c;
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c = 1;
    while (!rsp_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(lat));
    chk({tag, "_rdata"}, rsp_rdata, erd);
    chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, eerr});
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    int c, e0, w0, r0, a0;
    logic [31:0] b_addr [3];
    logic [2:0]  b_f3   [3];
    logic [31:0] b_exp  [3];

    // Reset values while rst_n is low
    #12;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_mem_en", {30'h0, mem_en, mem_we}, 32'h0);
    chk("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sub-word loads with sign/zero extension
    preload(32'h10, 32'h8899AABB);
    xact("lb",  1'b0, F3_B,  32'h11, 32'h0, 3, 32'hFFFFFFAA, 1'b0);
    xact("lbu", 1'b0, F3_BU, 32'h11, 32'h0, 3, 32'h000000AA, 1'b0);
    xact("lh",  1'b0, F3_H,  32'h12, 32'h0, 3, 32'hFFFF8899, 1'b0);
    xact("lhu", 1'b0, F3_HU, 32'h12, 32'h0, 3, 32'h00008899, 1'b0);

    // Word store then load back
    xact("sw", 1'b1, F3_W, 32'h20, 32'h12345678, 2, 32'h0, 1'b0);
    chk("sw_ram", ram[8], 32'h12345678);
    xact("lw", 1'b0, F3_W, 32'h20, 32'h0, 3, 32'h12345678, 1'b0);

    // Read-modify-write stores
    preload(32'h30, 32'h11223344);
    xact("sb", 1'b1, F3_B, 32'h31, 32'hFFFFFFAB, 4, 32'h0, 1'b0);
    chk("sb_ram", ram[12], 32'h1122AB44);
    xact("sh", 1'b1, F3_H, 32'h32, 32'h0000CDEF, 4, 32'h0, 1'b0);
    chk("sh_ram", ram[12], 32'hCDEFAB44);

    // Errors never touch memory
    e0 = en_cnt;
    xact("lw_mis",  1'b0, F3_W,   32'h22, 32'h0, 1, 32'h0, 1'b1);
    xact("sh_mis",  1'b1, F3_H,   32'h33, 32'hBEEF, 1, 32'h0, 1'b1);
    xact("ld_f011", 1'b0, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1);
    xact("st_f100", 1'b1, F3_BU,  32'h10, 32'h55, 1, 32'h0, 1'b1);
    chk("err_no_mem_en", 32'(en_cnt - e0), 32'h0);
    chk("err_ram_kept", ram[12], 32'hCDEFAB44);

    // Address wrap: 0x1040 maps onto word 0x10
    xact("sw_wrap", 1'b1, F3_W, 32'h00001040, 32'hCAFEF00D, 2, 32'h0, 1'b0);
    chk("wrap_ram", ram[16], 32'hCAFEF00D);

    // Back-to-back loads with req_valid held high
    b_addr[0] = 32'h20; b_f3[0] = F3_W;  b_exp[0] = 32'h12345678;
    b_addr[1] = 32'h13; b_f3[1] = F3_BU; b_exp[1] = 32'h00000088;
    b_addr[2] = 32'h30; b_f3[2] = F3_H;  b_exp[2] = 32'hFFFFAB44;
    a0 = acc_cnt;
    req_we = 1'b0; req_funct3 = b_f3[0]; req_addr = b_addr[0]; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i < 2) begin
        req_funct3 = b_f3[i+1];
        req_addr   = b_addr[i+1];
      end
      c = 1;
      while (!rsp_valid && c < 10) begin
        @(posedge clk); #1;
        c++;
      end
      chk($sformatf("b2b%0d_lat", i), 32'(c), 32'd3);
      chk($sformatf("b2b%0d_rdata", i), rsp_rdata, b_exp[i]);
      chk($sformatf("b2b%0d_busy", i), {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d_ready", i), {31'h0, req_ready}, 32'h1);
      if (i == 2) req_valid = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd3);

    // Reset during the merge cycle of a byte store
    preload(32'h60, 32'hA5A5A5A5);
    w0 = we_cnt; r0 = rsp_cnt;
    req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h61; req_wdata = 32'h77; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_en", {30'h0, mem_en, mem_we}, 32'h0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_no_write", 32'(we_cnt - w0), 32'h0);
    chk("abort_no_rsp", 32'(rsp_cnt - r0), 32'h0);
    chk("abort_ram_kept", ram[24], 32'hA5A5A5A5);
    xact("lw_after_rst", 1'b0, F3_W, 32'h60, 32'h0, 3, 32'hA5A5A5A5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Memory-side responder for the multicycle core's load/store path. It accepts one load or store request at a time from the core over a valid/ready handshake and drives a single-port synchronous word RAM with 1-cycle read latency and no byte enables. It performs byte-lane steering, sign/zero extension for loads and read-modify-write for sub-word stores, then returns a one-cycle response. It flags misaligned accesses and illegal funct3 values without touching memory.

Parameters:
MEM_AW, 10, word-address width of the RAM (depth 2**MEM_AW words)

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  1  core presents a request
req_ready  out  1  controller can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I load/store funct3
req_addr  in  32  byte address
req_wdata  in  32  store data; low byte/half used for SB/SH
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  formatted load data; 0 for stores and errors; held until next response
rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid; held like rsp_rdata
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write strobe, qualified by mem_en
mem_addr  out  MEM_AW  word address = addr_q[MEM_AW+1:2]
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

Behaviour:
- Reset (async assert): state=IDLE. All registers 0. rsp_valid, rsp_err, mem_en, mem_we = 0. rsp_rdata, mem_addr, mem_wdata = 0. req_ready = 1 (state decode). No request is accepted while rst_n is low.
- Accept: state IDLE and req_valid high at a clock edge. req_we, funct3 and addr are captured to *_q. Store data is captured to wbuf.
- Classification, done at accept:
  - Load legal funct3: 000, 001, 010, 100, 101.
  - Store legal funct3: 000, 001, 010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
  - Any error goes to RESP directly with err=1.
- FSM states: IDLE, RD, RDW, WR, RMW_RD, RMW_MRG, RMW_WR, RESP.
- Load path: IDLE→RD→RDW→RESP→IDLE.
  - RD: mem_en=1, mem_we=0.
  - RDW: mem_rdata is shifted right by 8*addr_q[1:0], extended per funct3, and registered into rsp_rdata.
- Word store path: IDLE→WR→RESP→IDLE.
  - WR: mem_en=1, mem_we=1, mem_wdata=wbuf.
- Sub-word store path: IDLE→RMW_RD→RMW_MRG→RMW_WR→RESP→IDLE.
  - RMW_MRG: the byte/half is inserted into mem_rdata at lane addr_q[1:0], and the result is registered into wbuf. Other lanes are unchanged.
  - RMW_WR: writes wbuf.
- Latency, in cycles after the accept edge at which rsp_valid is high:
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Error: 1.
- RESP lasts exactly 1 cycle. There is no response backpressure. req_ready returns high the cycle after RESP.
- mem_* outputs are decoded from state plus registers. mem_en=0 in IDLE, RESP and the merge/RDW states.
- Address bits above MEM_AW+1 are ignored, so addresses wrap modulo RAM size.
- Reset mid-operation: the FSM returns to IDLE immediately and mem_en/mem_we drop asynchronously.
  - A write not yet strobed is dropped.
  - No rsp_valid is produced for the aborted request.
- req_valid deasserting after accept has no effect. Request inputs are ignored outside IDLE.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum typedef.
  - Request struct (we, funct3, addr, wdata).
- One combinational sub-module, lane_fmt:
  - Load extract/extend (rdata, lane, funct3 → value).
  - Store insert (old word, data, lane, funct3 → merged word).

Test Plan:
- Preload word 0x8899AABB at addr 0x10; LB addr 0x11 → rsp_valid at +3, rsp_rdata=0xFFFFFFAA, err=0. LBU 0x11 → 0x000000AA. LH 0x12 → 0xFFFF8899. LHU 0x12 → 0x00008899.
- SW 0x12345678 to 0x20, then LW 0x20 → 0x12345678. Store rsp_valid at +2 with rdata=0.
- Preload 0x11223344 at 0x30; SB data 0xFFFFFFAB to 0x31 → rsp at +4; memory word becomes 0x1122AB44. SH 0xCDEF to 0x32 → 0xCDEFAB44.
- LW at 0x22, SH at 0x33, load with funct3=011 → rsp_valid at +1, err=1, rdata=0, mem_en never asserted.
- Back-to-back requests with req_valid held high → req_ready low between accepts, each request is accepted exactly once, and responses arrive in order.
- Assert rst_n low during RMW_MRG of SB → mem_we never pulses, RAM word unchanged, no rsp_valid. After release a new LW completes normally.
